if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch front end for the openmips SOPC: owns the PC, drives the synchronous inst ROM
//  (1-cycle read latency), and buffers fetched words in a small FIFO. Sits between inst_rom and the
//  if/id pipeline register; decode pulls {pc, inst} with a valid/ready handshake. Flush+redirect
//  support is provided for branch/exception stages added after chap4.
// PARAMETERS
//  DEPTH     4             FIFO entries; power of two, 2..16 (>=3 for 1 inst/cycle sustained)
//  RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//  clk         in   1   system clock, all state updates on posedge
//  rst         in   1   synchronous, active-high reset (`RstEnable = 1'b1)
//  flush_i     in   1   discard all buffered/in-flight fetches, redirect to new_pc_i
//  new_pc_i    in   32  redirect target, sampled only when flush_i=1
//  rom_ce_o    out  1   ROM chip enable / read request this cycle
//  rom_addr_o  out  32  ROM byte address (word aligned)
//  rom_data_i  in   32  ROM data; valid the cycle after a request with rom_ce_o=1
//  id_valid_o  out  1   head entry presented to decode
//  id_ready_i  in   1   decode accepts head entry this cycle
//  id_pc_o     out  32  PC of head entry
//  id_inst_o   out  32  instruction word of head entry
// BEHAVIOUR
//  Clock/reset: one clock domain, clk; rst synchronous, active-high; all state cleared on the rst edge.
//  Reset: pc<=RESET_PC, FIFO empty, pending<=0; rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0
//   while rst=1. First request issued in first cycle with rst=0.
//  Issue: rom_ce_o=1 iff !rst && !flush_i && (count + pending) < DEPTH; rom_addr_o=pc.
//   On issue: pc<=pc+4 (wraps 32'hFFFFFFFC -> 0), pending<=1; else pending<=0.
//  Latency: request cycle N (addr A) -> rom_data_i=mem[A] in N+1, written to FIFO at end of N+1
//   with its pc -> id_valid_o=1 in N+2. Steady state 1 inst/cycle when id_ready_i held high.
//  Handshake: transfer when id_valid_o && id_ready_i; head pops at that edge. id_pc_o/id_inst_o
//   stable while id_valid_o=1 and no transfer. id_valid_o = !empty && !flush_i.
//  Push and pop in same cycle: legal at any count incl. full; count unchanged.
//  Full: credit rule guarantees a returning word always has a slot; write-when-full never occurs
//   (bench asserts it).
//  Flush (priority over everything except rst): at the edge, FIFO emptied, pending response
//   dropped (next-cycle rom_data_i not written), pc<=new_pc_i; no issue and no transfer in the
//   flush cycle. First post-flush request next cycle at new_pc_i.
//  Back-to-back flushes: last one wins. Flush during rst: ignored.
//  rst mid-operation: discards everything exactly like flush, pc<=RESET_PC.
//  Arithmetic: count is $clog2(DEPTH)+1 bits; rd/wr pointers $clog2(DEPTH) bits, natural wrap.
//  new_pc_i[1:0] ignored (forced 2'b00).
// STRUCTURE
//  defines.v: `RstEnable, `ChipEnable/`ChipDisable, `InstAddrBus, `InstBus, `ZeroWord.
//  Sub-module fetch_fifo (DEPTH x 64b {pc,inst}, push/pop/clear, count, empty, full); top holds PC,
//   pending flag, credit logic and issue control.
// TESTING
//  T1 reset: rst=1 for 10 cycles -> rom_ce_o=0, id_valid_o=0; release -> addr 0,4,8 on cycles 1,2,3;
//   id_valid_o first high cycle 3 with pc=0, inst=mem[0].
//  T2 streaming: ready=1, ROM mem[i]=32'h3401_0000+i -> one transfer/cycle, pc 0,4,8.. in order, no gaps.
//  T3 backpressure: ready=0 for 20 cycles -> rom_ce_o stops after 4 outstanding; count=4, pc=0x10;
//   ready=1 -> entries pc 0,4,8,C delivered, fetch resumes at 0x10, no loss/duplication.
//  T4 flush: flush_i=1, new_pc_i=0x100 while FIFO holds 3 and one pending -> next cycle count=0,
//   rom_addr_o=0x100; first delivered pc=0x100; dropped word never appears.
//  T5 simultaneous: flush_i with id_ready_i=1 -> no transfer that cycle; flush two cycles in a row
//   (0x200 then 0x300) -> only 0x300 stream delivered.
//  T6 rst mid-stream with FIFO full -> all cleared, restart at RESET_PC; random ready with
//   scoreboard over 2000 cycles, no write-when-full assertion fires.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package if_fetch_queue_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;
  // Redirect targets are forced onto a word boundary.
  localparam logic [INST_ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

  // One buffered fetch: the word and the address it came from.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at the top of the address space.
  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Small {pc,inst} FIFO. Push and pop may coincide at any fill level, including
// full; clear empties it in one edge. Pop is never requested when empty and
// push is never requested when full (the fetch credit logic guarantees it).
module if_fetch_queue_fetch_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues reads to a 1-cycle ROM and
// buffers returned words for decode. A read is only issued while a FIFO slot is
// reserved for it (buffered + in-flight < DEPTH), so returning data always fits.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          pending_q, pending_d;
  // Address of the in-flight read, paired with its data on return.
  logic [31:0]   pend_pc_q, pend_pc_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_wdata;
  logic [CW:0]   inflight;
  logic          issue;

  // Issue when a slot is free for the word; push the word returning this cycle
  // unless a flush is discarding it.
  always_comb begin
    inflight   = {1'b0, fifo_count} + {{CW{1'b0}}, pending_q};
    issue      = !rst && !flush_i && (inflight < DEPTH_W);
    fifo_push  = !rst && !flush_i && pending_q;
    fifo_wdata = '{pc: pend_pc_q, inst: rom_data_i};
    id_valid_o = !rst && !flush_i && !fifo_empty;
    fifo_pop   = id_valid_o && id_ready_i;
  end

  // PC and in-flight tracking; a flush redirects and forgets the pending read.
  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pending_d = issue;
    if (flush_i) begin
      pc_d = new_pc_i & WORD_MASK;
    end else if (issue) begin
      pc_d      = next_pc(pc_q);
      pend_pc_d = pc_q;
    end
  end

  // Registers; reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      pend_pc_q <= ZERO_WORD;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  if_fetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (flush_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign rom_ce_o   = issue;
  assign rom_addr_o = pc_q;
  assign id_pc_o    = id_valid_o ? fifo_head.pc   : ZERO_WORD;
  assign id_inst_o  = id_valid_o ? fifo_head.inst : ZERO_WORD;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: ROM model, table-driven reset/fill vectors,
// directed flush sequences and a scoreboard over randomised ready/flush/reset.
module tb_if_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  if_fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .new_pc_i   (new_pc_i),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .id_valid_o (id_valid_o),
    .id_ready_i (id_ready_i),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h3401_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) if (rom_ce_o) rom_data_i <= rom_word(rom_addr_o);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          xfers  = 0;
  exp_t        sbq[$];
  logic [31:0] gen_pc = RST_PC;
  logic        hold_v = 1'b0;
  logic [31:0] hold_pc, hold_inst;
  vec_t        tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the negedge: scoreboard, hold-stability and overflow checks.
  task automatic monitor();
    exp_t e;
    chk("wr_when_full", {31'b0, dut.u_fetch_fifo.push_i && dut.u_fetch_fifo.full_o}, 32'd0);
    if (hold_v && !rst && !flush_i) begin
      chk("hold_valid", {31'b0, id_valid_o}, 32'd1);
      chk("hold_pc", id_pc_o, hold_pc);
      chk("hold_inst", id_inst_o, hold_inst);
    end
    while (sbq.size() < 8) begin
      sbq.push_back('{pc: gen_pc, inst: rom_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
    hold_v = 1'b0;
    if (rst) begin
      sbq.delete();
      gen_pc = RST_PC;
    end else if (flush_i) begin
      chk("flush_no_valid", {31'b0, id_valid_o}, 32'd0);
      sbq.delete();
      gen_pc = new_pc_i & 32'hFFFF_FFFC;
    end else if (id_valid_o && id_ready_i) begin
      e = sbq.pop_front();
      chk("sb_pc", id_pc_o, e.pc);
      chk("sb_inst", id_inst_o, e.inst);
      xfers++;
    end else begin
      hold_v    = id_valid_o;
      hold_pc   = id_pc_o;
      hold_inst = id_inst_o;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Step while requiring id_valid_o=1 (gap-free streaming).
  task automatic step_valid(input string name);
    @(negedge clk);
    chk(name, {31'b0, id_valid_o}, 32'd1);
    monitor();
    @(posedge clk);
    #1;
  endtask

  int x0;

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
    tv[2] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0};
    tv[4] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 32'h3401_0000};
    tv[5] = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0, 32'h3401_0000};
    tv[6] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 32'h3401_0000};
    tv[7] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 32'h3401_0000};

    rst = 1'b1; flush_i = 1'b0; new_pc_i = '0; id_ready_i = 1'b0;
    @(posedge clk); #1;

    // T1: reset held, then release with decode stalled.
    for (int i = 0; i < 9; i++) step();
    for (int i = 0; i < 8; i++) begin
      rst = tv[i].rst; id_ready_i = tv[i].ready;
      @(negedge clk);
      chk($sformatf("t1_ce[%0d]", i), {31'b0, rom_ce_o}, {31'b0, tv[i].ce});
      chk($sformatf("t1_addr[%0d]", i), rom_addr_o, tv[i].addr);
      chk($sformatf("t1_valid[%0d]", i), {31'b0, id_valid_o}, {31'b0, tv[i].valid});
      if (tv[i].valid || tv[i].rst) begin
        chk($sformatf("t1_pc[%0d]", i), id_pc_o, tv[i].pc);
        chk($sformatf("t1_inst[%0d]", i), id_inst_o, tv[i].inst);
      end
      monitor();
      @(posedge clk); #1;
    end

    // T3: long backpressure, then drain in order; T2: gap-free streaming.
    for (int i = 0; i < 12; i++) step();
    @(negedge clk);
    chk("t3_count", {29'b0, dut.u_fetch_fifo.count_o}, 32'd4);
    chk("t3_ce", {31'b0, rom_ce_o}, 32'd0);
    chk("t3_addr", rom_addr_o, 32'h10);
    monitor();
    @(posedge clk); #1;
    id_ready_i = 1'b1;
    x0 = xfers;
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 20; i++) step_valid("t2_stream_valid");
    chk("t2_xfers", xfers - x0, 32'd30);

    // T4: flush with 3 buffered and one in flight.
    rst = 1'b1; id_ready_i = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    flush_i = 1'b1; new_pc_i = 32'h0000_0103; id_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_count_pre", {29'b0, dut.u_fetch_fifo.count_o}, 32'd3);
    chk("t4_pending_pre", {31'b0, dut.pending_q}, 32'd1);
    chk("t4_ce_flush", {31'b0, rom_ce_o}, 32'd0);
    monitor();
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("t4_count_post", {29'b0, dut.u_fetch_fifo.count_o}, 32'd0);
    chk("t4_ce_post", {31'b0, rom_ce_o}, 32'd1);
    chk("t4_addr_post", rom_addr_o, 32'h100);
    monitor();
    @(posedge clk); #1;
    step();
    @(negedge clk);
    chk("t4_first_pc", id_pc_o, 32'h100);
    monitor();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) step();

    // T5: flush while decode is ready, then back-to-back flushes.
    flush_i = 1'b1; new_pc_i = 32'h200;
    step();
    new_pc_i = 32'h300;
    step();
    flush_i = 1'b0;
    x0 = xfers;
    for (int i = 0; i < 12; i++) step();
    chk("t5_xfers", xfers - x0, 32'd10);

    // T6: reset while full, then randomised traffic.
    id_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    @(negedge clk);
    chk("t6_full", {31'b0, dut.u_fetch_fifo.full_o}, 32'd1);
    monitor();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ce", {31'b0, rom_ce_o}, 32'd0);
    chk("t6_rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("t6_rst_pc", id_pc_o, 32'h0);
    chk("t6_rst_inst", id_inst_o, 32'h0);
    monitor();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_count", {29'b0, dut.u_fetch_fifo.count_o}, 32'd0);
    chk("t6_ce", {31'b0, rom_ce_o}, 32'd1);
    chk("t6_addr", rom_addr_o, RST_PC);
    monitor();
    @(posedge clk); #1;
    x0 = xfers;
    for (int i = 0; i < 2000; i++) begin
      id_ready_i = 1'($urandom_range(0, 1));
      flush_i    = ($urandom_range(0, 63) == 0);
      new_pc_i   = $urandom;
      rst        = ($urandom_range(0, 255) == 0);
      step();
    end
    rst = 1'b0; flush_i = 1'b0;
    chk("t6_progress", {31'b0, (xfers - x0) > 500}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
